// File: rtl/dsa_avalon_master.sv
// Avalon-MM master issuing single-word block reads/writes into the DSA window.
// Optional read timeout is enabled by defining DSA_AVM_TIMEOUT_EN.
module dsa_avalon_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int LEN_WIDTH      = 12,
  parameter int ADDR_STEP      = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [31:0]           wd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [3:0]            avm_byteenable,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_RSP, FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  done_q, done_d;
  logic                  tmo_hit;

`ifdef DSA_AVM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // tmo_q counts completed RD_WAIT cycles; the last allowed one triggers the abort
  assign tmo_hit = (state_q == RD_WAIT) && !avm_readdatavalid &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (state_q == RD_WAIT && state_d == RD_WAIT) tmo_d = tmo_q + 1'b1;
    err_d = err_q | tmo_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;
    wd_ready    = 1'b0;
    avm_read    = 1'b0;
    avm_write   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len == '0)  state_d = FINISH;
          else if (cmd_write) state_d = WR_DATA;
          else                state_d = RD_ISSUE;
        end
      end
      WR_DATA: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          wdata_d = wd_data;
          state_d = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          addr_d  = addr_q + STEP;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_WIDTH'(1)) ? FINISH : WR_DATA;
        end
      end
      RD_ISSUE: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          // a zero-latency slave returns data in the acceptance cycle
          if (avm_readdatavalid) begin
            rdata_d     = avm_readdata;
            rsp_valid_d = 1'b1;
            addr_d      = addr_q + STEP;
            rem_d       = rem_q - 1'b1;
            state_d     = RD_RSP;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_d     = avm_readdata;
          rsp_valid_d = 1'b1;
          addr_d      = addr_q + STEP;
          rem_d       = rem_q - 1'b1;
          state_d     = RD_RSP;
        end else if (tmo_hit) begin
          state_d = FINISH;
        end
      end
      RD_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = (rem_q == '0) ? FINISH : RD_ISSUE;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rdata_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = (avm_read || avm_write) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_dsa_avalon_master.sv
// Scoreboard bench for dsa_avalon_master: random Avalon slave, expected bus
// writes and read responses derived from a flat memory model of the DSA window.
module tb_dsa_avalon_master;
  localparam int AW = 16;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wd_valid, wd_ready;
  logic [31:0]   wd_data;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_data;
  logic          busy, done, err;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_writedata, avm_readdata;
  logic          avm_readdatavalid, avm_waitrequest;

  dsa_avalon_master #(
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ADDR_STEP(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .done(done), .err(err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [0:65535];
  logic [31:0] smem    [0:65535];
  logic [47:0] exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] wd_q   [$];
  logic [31:0] fix_q  [$];

  int wait_pct = 0, fixed_wait = 0, min_lat = 1, max_lat = 1;
  int rdy_pct = 100, wd_pct = 100;
  bit unsol_en = 1'b0, stall_arm = 1'b0;
  int stall_cnt = 0, outstanding = 0, pend = 0, wcnt = 0;
  logic [15:0] paddr;
  int traffic = 0, done_cnt = 0, cmds = 0;

  function automatic logic [31:0] init_val(input int a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: DUT did not respond within the cycle budget", nm);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench aborted");
  endtask

  // Slave, write-data source, response sink and bus monitors, all at negedge.
  initial begin
    int lat;
    logic [47:0] e;
    avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    rsp_ready = 1'b0; wd_valid = 1'b0; wd_data = '0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = smem[paddr];
          outstanding--;
        end
      end
      if (fixed_wait > 0) avm_waitrequest = avm_read && (wcnt < fixed_wait);
      else avm_waitrequest = ($urandom_range(99, 0) < wait_pct);
      if (avm_read) begin
        chk("one_outstanding", outstanding, 0);
        chk("read_while_rsp_valid", longint'(rsp_valid), 0);
        if (!avm_waitrequest) begin
          wcnt = 0;
          lat  = $urandom_range(max_lat, min_lat);
          outstanding++;
          if (lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = smem[avm_address];
            outstanding--;
          end else begin
            pend  = lat;
            paddr = avm_address;
          end
        end else begin
          wcnt++;
        end
      end else if (unsol_en && pend == 0 && $urandom_range(7, 0) == 0) begin
        avm_readdatavalid = 1'b1;
      end
      if (avm_write && !avm_waitrequest) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", longint'(avm_address), longint'(e[47:32]));
          chk("wr_data", longint'(avm_writedata), longint'(e[31:0]));
        end
        smem[avm_address] = avm_writedata;
      end
      if (avm_read || avm_write) traffic++;
      chk("byteenable", longint'(avm_byteenable), (avm_read || avm_write) ? 15 : 0);
      if (stall_cnt > 0) begin
        rsp_ready = 1'b0;
        stall_cnt--;
      end else begin
        rsp_ready = ($urandom_range(99, 0) < rdy_pct);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rd.size() == 0) chk("unexpected_rsp", 1, 0);
        else chk("rsp_data", longint'(rsp_data), longint'(exp_rd.pop_front()));
        if (stall_arm) begin
          stall_arm = 1'b0;
          stall_cnt = 10;
        end
      end
      if (wd_q.size() > 0 && (wd_valid || $urandom_range(99, 0) < wd_pct)) begin
        wd_valid = 1'b1;
        wd_data  = wd_q[0];
      end else begin
        wd_valid = 1'b0;
        wd_data  = $urandom;
      end
      if (wd_valid && wd_ready) void'(wd_q.pop_front());
      if (done) done_cnt++;
    end
  end

  // Queue the expectations of one block, issue it, and wait for its done pulse.
  task automatic run_cmd(input bit wr, input logic [15:0] a, input int len,
                         input bit expect_rsp, output int acc, output int dcyc);
    logic [15:0] ad;
    logic [31:0] d;
    int n;
    for (int i = 0; i < len; i++) begin
      ad = a + 16'(i);
      if (wr) begin
        if (fix_q.size() > 0) d = fix_q.pop_front();
        else d = $urandom;
        ref_mem[ad] = d;
        exp_wr.push_back({ad, d});
        wd_q.push_back(d);
      end else if (expect_rsp) begin
        exp_rd.push_back(ref_mem[ad]);
      end
    end
    unsol_en = wr;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) bail("cmd_ready_wait");
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = LW'(len);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_len = LW'($urandom);
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!done) bail("done_wait");
    dcyc = cyc;
    @(posedge clk);
    #1;
    unsol_en = 1'b0;
    chk("busy_after_done", longint'(busy), 0);
    chk("done_one_cycle", longint'(done), 0);
    chk("writes_drained", exp_wr.size(), 0);
    chk("reads_drained", exp_rd.size(), 0);
    chk("wdata_consumed", wd_q.size(), 0);
  endtask

  initial begin
    int acc, dc, t0, len;
    logic [15:0] a;
    bit wr;
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = init_val(i);
      smem[i]    = init_val(i);
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", longint'(cmd_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_avm_read", longint'(avm_read), 0);
    chk("rst_avm_write", longint'(avm_write), 0);
    chk("rst_rsp_valid", longint'(rsp_valid), 0);
    chk("rst_wd_ready", longint'(wd_ready), 0);
    chk("rst_address", longint'(avm_address), 0);
    chk("rst_writedata", longint'(avm_writedata), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain write block, no stalls.
    fix_q.push_back(32'h11); fix_q.push_back(32'h22); fix_q.push_back(32'h33);
    run_cmd(1'b1, 16'h0010, 3, 1'b1, acc, dc); cmds++;
    chk("mem_after_write", longint'(smem[16'h0012]), 32'h33);

    // Read with two waitrequest cycles per read and latency 3.
    fixed_wait = 2; min_lat = 3; max_lat = 3;
    run_cmd(1'b0, 16'h0020, 2, 1'b1, acc, dc); cmds++;
    fixed_wait = 0;

    // Response back-pressure after the first word.
    wait_pct = 20; min_lat = 0; max_lat = 2; stall_arm = 1'b1;
    run_cmd(1'b0, 16'h0300, 4, 1'b1, acc, dc); cmds++;
    chk("stall_consumed", longint'(stall_arm), 0);

    // Zero-length commands.
    t0 = traffic;
    run_cmd(1'b0, 16'h0040, 0, 1'b1, acc, dc); cmds++;
    chk("len0_rd_latency", dc - acc, 2);
    chk("len0_rd_traffic", traffic - t0, 0);
    t0 = traffic;
    run_cmd(1'b1, 16'h0050, 0, 1'b1, acc, dc); cmds++;
    chk("len0_wr_latency", dc - acc, 2);
    chk("len0_wr_traffic", traffic - t0, 0);

    // Address wrap, then read it back; then zero-latency read-back of the first block.
    wait_pct = 0;
    run_cmd(1'b1, 16'hFFFF, 2, 1'b1, acc, dc); cmds++;
    chk("wrap_mem0", longint'(smem[0]), longint'(ref_mem[0]));
    run_cmd(1'b0, 16'hFFFF, 2, 1'b1, acc, dc); cmds++;
    min_lat = 0; max_lat = 0;
    run_cmd(1'b0, 16'h0010, 3, 1'b1, acc, dc); cmds++;

    // Reset while a read is in flight.
    min_lat = 8; max_lat = 8;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0500; cmd_len = LW'(3);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_avm_read", longint'(avm_read), 0);
    chk("abort_rsp_valid", longint'(rsp_valid), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_cmd_ready", longint'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("stray_rdv_rsp_valid", longint'(rsp_valid), 0);
    chk("stray_rdv_busy", longint'(busy), 0);

`ifdef DSA_AVM_TIMEOUT_EN
    // Slave answers far too late; the master must give up after 8 wait cycles.
    min_lat = 60; max_lat = 60;
    run_cmd(1'b0, 16'h0600, 2, 1'b0, acc, dc); cmds++;
    chk("tmo_done_latency", dc - acc, 11);
    chk("tmo_err", longint'(err), 1);
    repeat (70) @(negedge clk);
    min_lat = 1; max_lat = 3;
    run_cmd(1'b1, 16'h0700, 2, 1'b1, acc, dc); cmds++;
    chk("tmo_err_sticky", longint'(err), 1);
`endif

    // Random blocks.
    for (int k = 0; k < 40; k++) begin
      wait_pct = $urandom_range(60, 0);
      min_lat  = 0;
      max_lat  = $urandom_range(5, 0);
      rdy_pct  = $urandom_range(100, 30);
      wd_pct   = $urandom_range(100, 30);
      if ($urandom_range(3, 0) == 0) a = 16'hFFFF - 16'($urandom_range(3, 0));
      else a = 16'($urandom_range(255, 0));
      len = $urandom_range(6, 0);
      wr  = 1'($urandom_range(1, 0));
      run_cmd(wr, a, len, 1'b1, acc, dc); cmds++;
    end

    repeat (5) @(negedge clk);
    chk("done_pulse_count", done_cnt, cmds);
`ifndef DSA_AVM_TIMEOUT_EN
    chk("err_tied_low", longint'(err), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
